// File: rtl/ls163_sync_counter_pkg.sv
// Shared constants and priority-action encoding for the LS163 counter emulation.
package ls163_sync_counter_pkg;
   localparam int LS163_WIDTH = 4;
   localparam logic [LS163_WIDTH-1:0] LS163_TC = {LS163_WIDTH{1'b1}};

   typedef enum logic [1:0] {
      ACT_CLR   = 2'd0,
      ACT_LOAD  = 2'd1,
      ACT_COUNT = 2'd2,
      ACT_HOLD  = 2'd3
   } ls163_act_e;

   // Clear beats load beats count; load ignores both enables.
   function automatic ls163_act_e ls163_action(input logic clr_n, input logic load_n,
                                               input logic enp, input logic ent);
      if (!clr_n)          return ACT_CLR;
      else if (!load_n)    return ACT_LOAD;
      else if (enp && ent) return ACT_COUNT;
      else                 return ACT_HOLD;
   endfunction
endpackage

// File: rtl/ls163_next_state.sv
// Combinational next-Q selection for the LS163 counter.
module ls163_next_state
   import ls163_sync_counter_pkg::*;
#(
   parameter int WIDTH = LS163_WIDTH
) (
   input  logic             clr_n,
   input  logic             load_n,
   input  logic             enp,
   input  logic             ent,
   input  logic [WIDTH-1:0] d,
   input  logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_next,
   output ls163_act_e       act
);
   always_comb begin
      act    = ls163_action(clr_n, load_n, enp, ent);
      q_next = q;
      unique case (act)
         ACT_CLR:   q_next = '0;
         ACT_LOAD:  q_next = d;
         ACT_COUNT: q_next = q + WIDTH'(1);
         default:   q_next = q;
      endcase
   end
endmodule

// File: rtl/ls163_sync_counter.sv
// SN74LS163A-style synchronous counter: async emulator reset, Q register, combinational RCO.
module ls163_sync_counter
   import ls163_sync_counter_pkg::*;
#(
   parameter int WIDTH = LS163_WIDTH
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             CLR_N,
   input  logic             LOAD_N,
   input  logic             ENP,
   input  logic             ENT,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q,
   output logic             RCO
);
   logic [WIDTH-1:0] q_next;
   ls163_act_e       act;

   ls163_next_state #(.WIDTH(WIDTH)) u_next (
      .clr_n  (CLR_N),
      .load_n (LOAD_N),
      .enp    (ENP),
      .ent    (ENT),
      .d      (D),
      .q      (Q),
      .q_next (q_next),
      .act    (act)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) Q <= '0;
      else     Q <= q_next;
   end

   assign RCO = ENT & (Q == {WIDTH{1'b1}});

   always_comb begin
      assert (!RCO || ENT);
   end

   // Snapshot taken mid-cycle; Q must not move again before the next rising edge.
   logic [WIDTH-1:0] q_mid;
   always_ff @(negedge CLK or posedge RST) begin
      if (RST) q_mid <= '0;
      else     q_mid <= Q;
   end

   a_q_edge_only: assert property (@(posedge CLK) disable iff (RST) Q == q_mid);

   c_clr:   cover property (@(posedge CLK) disable iff (RST) act == ACT_CLR);
   c_load:  cover property (@(posedge CLK) disable iff (RST) act == ACT_LOAD);
   c_count: cover property (@(posedge CLK) disable iff (RST) act == ACT_COUNT);
   c_hold:  cover property (@(posedge CLK) disable iff (RST) act == ACT_HOLD);
endmodule
